// File: rtl/spike_timestamp_fifo.sv
// spike_timestamp_fifo
//   Captures rising edges on asynchronous spike lines, stamps each with the
//   free-running count value at detection, and queues {channel, timestamp}
//   words in a FIFO drained by the management SoC over a register bus.
//
// Ports:
//   clk       - single clock for all logic
//   reset_n   - asynchronous active-low reset
//   spike_in  - [CH-1:0] asynchronous spike lines, active-high pulses
//   count     - [BITS-1:0] timestamp source
//   valid     - bus request
//   we        - 1 = write, 0 = read
//   addr      - [1:0] 0 DATA, 1 STATUS, 2 CTRL, 3 CMD
//   wdata     - [31:0] write data
//   ready     - one-cycle acknowledge
//   rdata     - [31:0] read data, valid while ready = 1
//   irq       - registered fill-level threshold interrupt
//
// Handshake: a request is taken when valid = 1 and ready = 0 at a clock edge.
// At that edge the register action happens, rdata is loaded and ready rises
// for exactly one cycle. Because ready = 1 blocks acceptance, a requester that
// holds valid high is acknowledged every other cycle.
module spike_timestamp_fifo #(
    parameter int BITS  = 24,
    parameter int CH    = 8,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [CH-1:0]   spike_in,
    input  logic [BITS-1:0] count,
    input  logic            valid,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic            ready,
    output logic [31:0]     rdata,
    output logic            irq
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    // Only 16 mask bits fit below the thresh field of CTRL.
    localparam int MW = (CH < 16) ? CH : 16;

    // Input capture state
    logic [CH-1:0]   sync1;
    logic [CH-1:0]   sync2;
    logic [CH-1:0]   prev;
    logic [CH-1:0]   pend;
    logic [BITS-1:0] ts_hold [CH];

    // Control registers
    logic [MW-1:0]   mask;
    logic [7:0]      thresh;
    logic            overflow;

    // FIFO state
    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level;

    // Combinational helpers
    logic [CH-1:0]   mask_eff;
    logic [CH-1:0]   rise;
    logic [CH-1:0]   accept;
    logic [CH-1:0]   drop;
    logic [CH-1:0]   push_sel;
    logic [7:0]      push_ch;
    logic [BITS-1:0] push_ts;
    logic [31:0]     push_entry;
    logic            found;
    logic            empty;
    logic            full;
    logic            acc;
    logic            pop;
    logic            push;
    logic            flush;
    logic            clr_ovf;
    logic            wr_ctrl;
    logic [LW-1:0]   level_next;
    logic            irq_next;
    logic [31:0]     status_word;
    logic [31:0]     ctrl_word;
    logic            unused_wdata;

    // Channels beyond the mask width share the top mask bit.
    for (genvar g = 0; g < CH; g++) begin : g_mask
        assign mask_eff[g] = mask[(g < MW) ? g : MW - 1];
    end

    assign rise   = sync2 & ~prev & mask_eff;
    assign drop   = rise & pend;
    assign accept = rise & ~pend;

    // Lowest-index pending channel wins the single push slot.
    always_comb begin
        found    = 1'b0;
        push_sel = '0;
        push_ch  = '0;
        push_ts  = '0;
        for (int i = 0; i < CH; i++) begin
            if (pend[i] && !found) begin
                found       = 1'b1;
                push_sel[i] = 1'b1;
                push_ch     = 8'(i);
                push_ts     = ts_hold[i];
            end
        end
    end

    assign push_entry = {push_ch, 24'(push_ts)};

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));

    assign acc     = valid && !ready;
    assign pop     = acc && !we && (addr == 2'd0) && !empty;
    assign wr_ctrl = acc && we && (addr == 2'd2);
    assign flush   = acc && we && (addr == 2'd3) && wdata[0];
    assign clr_ovf = acc && we && (addr == 2'd3) && wdata[1];

    // A pop frees a slot in the same cycle, so a full FIFO can still push.
    // A flush discards whatever would have been pushed.
    assign push = (pend != '0) && (!full || pop) && !flush;

    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    assign irq_next = (thresh != 8'd0) && (9'(level_next) >= 9'(thresh));

    assign status_word = {16'd0, 8'(level), 5'd0, overflow, full, empty};

    always_comb begin
        ctrl_word          = '0;
        ctrl_word[MW-1:0]  = mask;
        ctrl_word[23:16]   = thresh;
    end

    assign unused_wdata = ^wdata;

    // Storage has no reset; level and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            pend     <= '0;
            for (int i = 0; i < CH; i++) begin
                ts_hold[i] <= '0;
            end
            mask     <= '0;
            thresh   <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready    <= 1'b0;
            rdata    <= '0;
            irq      <= 1'b0;
        end else begin
            sync1 <= spike_in;
            sync2 <= sync1;
            prev  <= sync2;

            // In a flush cycle every detected edge starts fresh after the
            // flush; otherwise an edge on an already pending channel is lost.
            if (flush) begin
                pend <= rise;
            end else begin
                pend <= (pend & ~(push ? push_sel : '0)) | accept;
            end
            for (int i = 0; i < CH; i++) begin
                if (flush ? rise[i] : accept[i]) begin
                    ts_hold[i] <= count;
                end
            end

            if (flush) begin
                overflow <= 1'b0;
            end else if (drop != '0) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            level <= level_next;
            irq   <= irq_next;

            if (wr_ctrl) begin
                mask   <= wdata[MW-1:0];
                thresh <= wdata[23:16];
            end

            if (acc) begin
                ready <= 1'b1;
                if (we) begin
                    rdata <= '0;
                end else begin
                    case (addr)
                        2'd0:    rdata <= empty ? 32'd0 : mem[rd_ptr];
                        2'd1:    rdata <= status_word;
                        2'd2:    rdata <= ctrl_word;
                        default: rdata <= 32'd0;
                    endcase
                end
            end else begin
                ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_timestamp_fifo.sv
// tb_spike_timestamp_fifo
//   Bench for spike_timestamp_fifo: register vector table, FIFO entry
//   scoreboard and hand-written sequences for full/overflow, irq, flush and
//   asynchronous reset.
module tb_spike_timestamp_fifo;

    localparam int CH   = 8;
    localparam int BITS = 24;

    logic            clk      = 1'b0;
    logic            reset_n  = 1'b0;
    logic [CH-1:0]   spike_in = '0;
    logic [BITS-1:0] count    = 24'd100;
    logic            valid    = 1'b0;
    logic            we       = 1'b0;
    logic [1:0]      addr     = 2'd0;
    logic [31:0]     wdata    = '0;
    logic            ready;
    logic [31:0]     rdata;
    logic            irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    spike_timestamp_fifo #(.BITS(BITS), .CH(CH), .DEPTH(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spike_in (spike_in),
        .count    (count),
        .valid    (valid),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .rdata    (rdata),
        .irq      (irq)
    );

    // Clock and free-running timestamp ramp (+1 per cycle, changes after edge)
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 count = count + 24'd1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus transaction; ready must appear at the first sampling point.
    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        @(negedge clk);
        valid = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 4);
        check("bus_latency", 32'(n), 32'd1);
        r     = rdata;
        valid = 1'b0;
        we    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, a, 32'd0, r);
        check(name, r, exp);
    endtask

    task automatic read_data(input string name);
        logic [31:0] r;
        logic [31:0] e;
        bus(1'b0, 2'd0, 32'd0, r);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = 32'd0;
        end
        check(name, r, e);
    endtask

    // One-cycle pulse; when entries are expected the timestamp is the count
    // sampled two edges after the edge that samples the pulse.
    task automatic pulse(input logic [CH-1:0] m, input bit expect_entries);
        logic [BITS-1:0] c;
        @(negedge clk);
        spike_in = m;
        c = count;
        if (expect_entries) begin
            for (int i = 0; i < CH; i++) begin
                if (m[i]) begin
                    exp_q.push_back({8'(i), c + 24'd2});
                end
            end
        end
        @(negedge clk);
        spike_in = '0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd1, 32'h0,          1'b1, 32'h0000_0001};
        vecs[1]  = '{1'b0, 2'd3, 32'h0,          1'b1, 32'h0000_0000};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,          1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 2'd2, 32'h0005_0081,  1'b0, 32'h0};
        vecs[4]  = '{1'b0, 2'd2, 32'h0,          1'b1, 32'h0005_0081};
        vecs[5]  = '{1'b1, 2'd0, 32'hDEAD_BEEF,  1'b0, 32'h0};
        vecs[6]  = '{1'b1, 2'd1, 32'hFFFF_FFFF,  1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'd1, 32'h0,          1'b1, 32'h0000_0001};
        vecs[8]  = '{1'b1, 2'd2, 32'hFFFF_FFFF,  1'b0, 32'h0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,          1'b1, 32'h00FF_00FF};
        vecs[10] = '{1'b1, 2'd3, 32'h0,          1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'd2, 32'h0,          1'b1, 32'h00FF_00FF};
        vecs[12] = '{1'b1, 2'd2, 32'h0,          1'b0, 32'h0};
        vecs[13] = '{1'b0, 2'd2, 32'h0,          1'b1, 32'h0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Register vector table
        for (int i = 0; i < 14; i++) begin
            logic [31:0] r;
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, r);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d", i), r, vecs[i].exp);
            end
        end

        // Single channel capture and masking
        wr(2'd2, 32'h0000_0001);
        pulse(8'h01, 1'b1);
        idle(4);
        read_data("ch0_entry");
        rd_check("ch0_status_empty", 2'd1, 32'h0000_0001);
        pulse(8'h02, 1'b0);
        idle(4);
        rd_check("masked_status", 2'd1, 32'h0000_0001);

        // Simultaneous rising edges
        wr(2'd2, 32'h0000_00FF);
        pulse(8'h24, 1'b1);
        idle(4);
        rd_check("two_level", 2'd1, 32'h0000_0200);
        read_data("simul_first");
        read_data("simul_second");

        // Fill to full, hold the 17th, then overflow on its re-fire
        for (int i = 0; i < 17; i++) begin
            pulse(8'(1 << (i % CH)), 1'b1);
            idle(3);
        end
        idle(4);
        rd_check("full_status", 2'd1, 32'h0000_1002);
        pulse(8'h01, 1'b0);
        idle(4);
        rd_check("ovf_status", 2'd1, 32'h0000_1006);
        for (int i = 0; i < 17; i++) begin
            read_data($sformatf("drain%0d", i));
        end
        rd_check("drained_status", 2'd1, 32'h0000_0005);

        // Threshold interrupt
        wr(2'd2, 32'h0004_00FF);
        pulse(8'h0F, 1'b1);
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            check($sformatf("irq_rise_c%0d", j), {31'd0, irq}, (j >= 6) ? 32'd1 : 32'd0);
        end
        read_data("irq_pop");
        check("irq_fall", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            read_data($sformatf("irq_drain%0d", i));
        end

        // Empty read and flush
        read_data("empty_read");
        rd_check("empty_status", 2'd1, 32'h0000_0005);
        pulse(8'h07, 1'b1);
        idle(5);
        rd_check("pre_flush_status", 2'd1, 32'h0000_0304);
        wr(2'd3, 32'h0000_0001);
        rd_check("post_flush_status", 2'd1, 32'h0000_0001);
        exp_q.delete();

        // Asynchronous reset during a read
        wr(2'd2, 32'h0001_00FF);
        pulse(8'h03, 1'b1);
        idle(5);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        valid = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        @(posedge clk);
        #2;
        check("pre_rst_ready", {31'd0, ready}, 32'd1);
        check("pre_rst_rdata", rdata, exp_q[0]);
        reset_n = 1'b0;
        #1;
        check("async_ready", {31'd0, ready}, 32'd0);
        check("async_irq", {31'd0, irq}, 32'd0);
        check("async_rdata", rdata, 32'd0);
        valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        rd_check("post_rst_status", 2'd1, 32'h0000_0001);
        rd_check("post_rst_ctrl", 2'd2, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
